// File: rtl/fp16_pkg.sv
// Shared binary16 constants, field layout and pipeline payload types for the
// float16 arithmetic unit.
package fp16_pkg;

    localparam int FLOAT_LEN = 16;
    localparam int EXP_LEN   = 5;
    localparam int MANT_LEN  = 10;
    localparam int GRS_LEN   = 5;
    localparam int SIG_LEN   = MANT_LEN + 1 + GRS_LEN;

    localparam logic [EXP_LEN-1:0]   EXP_MAX = 5'h1F;
    localparam int                   BIAS    = 15;
    localparam logic [FLOAT_LEN-1:0] QNAN    = 16'h7E00;
    localparam logic [FLOAT_LEN-1:0] POS_INF = 16'h7C00;

    localparam int FLG_INVALID  = 2;
    localparam int FLG_OVERFLOW = 1;
    localparam int FLG_INEXACT  = 0;

    typedef struct packed {
        logic                sign;
        logic [EXP_LEN-1:0]  exp;
        logic [MANT_LEN-1:0] mant;
    } fp16_t;

    typedef struct packed {
        logic                 special;
        logic [FLOAT_LEN-1:0] special_res;
        logic                 special_inv;
        logic                 sign;
        logic                 zero_neg;
        logic                 eff_sub;
        logic [EXP_LEN-1:0]   exp;
        logic [SIG_LEN-1:0]   mant_l;
        logic [SIG_LEN-1:0]   mant_s;
    } s1_t;

    typedef struct packed {
        logic                 special;
        logic [FLOAT_LEN-1:0] special_res;
        logic                 special_inv;
        logic                 sign;
        logic                 zero_neg;
        logic [EXP_LEN-1:0]   exp;
        logic [SIG_LEN:0]     sum;
        logic [4:0]           lzc;
    } s2_t;

endpackage

// File: rtl/fp16_lzc.sv
// 17-bit leading-zero counter; an all-zero input reports 17.
module fp16_lzc (
    input  logic [16:0] din,
    output logic [4:0]  count
);

    always_comb begin
        count = 5'd17;
        // Scanning upward lets the most significant set bit win.
        for (int unsigned i = 0; i < 17; i++) begin
            if (din[i]) count = 5'(16 - i);
        end
    end

endmodule

// File: rtl/float16_subtractor_pipe.sv
// Three-stage binary16 subtractor (a - b, round-to-nearest-even) with a
// valid/ready streaming interface, gradual underflow and exception flags.
module float16_subtractor_pipe
    import fp16_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FLOAT_LEN-1:0] a,
    input  logic [FLOAT_LEN-1:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FLOAT_LEN-1:0] result,
    output logic [2:0]           flags
);

    logic s1_valid, s2_valid;
    logic s1_adv, s2_adv, s3_adv;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;

    always_comb begin
        s3_adv   = !out_valid || out_ready;
        s2_adv   = !s2_valid || s3_adv;
        s1_adv   = !s1_valid || s2_adv;
        in_ready = s1_adv;
    end

    // ---------------- S1: unpack / align ----------------
    fp16_t               fa, fb;
    logic                sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_ge;
    logic [EXP_LEN-1:0]  lx, sx, el, es, d;
    logic [MANT_LEN-1:0] lm, sm;
    logic [SIG_LEN-1:0]  ms, mask;

    always_comb begin
        fa     = a;
        fb     = b;
        sb     = ~fb.sign;
        a_nan  = (fa.exp == EXP_MAX) && (fa.mant != '0);
        b_nan  = (fb.exp == EXP_MAX) && (fb.mant != '0);
        a_inf  = (fa.exp == EXP_MAX) && (fa.mant == '0);
        b_inf  = (fb.exp == EXP_MAX) && (fb.mant == '0);
        a_zero = (fa.exp == '0) && (fa.mant == '0);
        b_zero = (fb.exp == '0) && (fb.mant == '0);
        a_ge   = {fa.exp, fa.mant} >= {fb.exp, fb.mant};
        lx     = a_ge ? fa.exp  : fb.exp;
        lm     = a_ge ? fa.mant : fb.mant;
        sx     = a_ge ? fb.exp  : fa.exp;
        sm     = a_ge ? fb.mant : fa.mant;
        el     = (lx == '0) ? 5'd1 : lx;
        es     = (sx == '0) ? 5'd1 : sx;
        d      = el - es;
        ms     = {sx != '0, sm, 5'b0};
        mask   = ~(16'hFFFF << d);

        s1_d          = '0;
        s1_d.sign     = a_ge ? fa.sign : sb;
        s1_d.zero_neg = a_zero && b_zero && fa.sign && !fb.sign;
        s1_d.eff_sub  = fa.sign ^ sb;
        s1_d.exp      = el;
        s1_d.mant_l   = {lx != '0, lm, 5'b0};
        if (d >= 5'd16) s1_d.mant_s = {15'b0, |ms};
        else            s1_d.mant_s = (ms >> d) | {15'b0, |(ms & mask)};

        if (a_nan || b_nan) begin
            s1_d.special     = 1'b1;
            s1_d.special_res = QNAN;
            s1_d.special_inv = (a_nan && !fa.mant[9]) || (b_nan && !fb.mant[9]);
        end else if (a_inf && b_inf && (fa.sign == fb.sign)) begin
            s1_d.special     = 1'b1;
            s1_d.special_res = QNAN;
            s1_d.special_inv = 1'b1;
        end else if (a_inf) begin
            s1_d.special     = 1'b1;
            s1_d.special_res = a;
        end else if (b_inf) begin
            s1_d.special     = 1'b1;
            s1_d.special_res = {~fb.sign, b[14:0]};
        end
    end

    // ---------------- S2: add / leading-zero count ----------------
    logic [SIG_LEN:0] s2_sum;
    logic [4:0]       s2_lzc;

    always_comb begin
        if (s1_q.eff_sub) s2_sum = {1'b0, s1_q.mant_l} - {1'b0, s1_q.mant_s};
        else              s2_sum = {1'b0, s1_q.mant_l} + {1'b0, s1_q.mant_s};
    end

    fp16_lzc u_lzc (
        .din   (s2_sum),
        .count (s2_lzc)
    );

    always_comb begin
        s2_d             = '0;
        s2_d.special     = s1_q.special;
        s2_d.special_res = s1_q.special_res;
        s2_d.special_inv = s1_q.special_inv;
        s2_d.sign        = s1_q.sign;
        s2_d.zero_neg    = s1_q.zero_neg;
        s2_d.exp         = s1_q.exp;
        s2_d.sum         = s2_sum;
        s2_d.lzc         = s2_lzc;
    end

    // ---------------- S3: normalize / round / pack ----------------
    logic [SIG_LEN-1:0]   norm;
    logic [5:0]           exp6;
    logic [4:0]           lz, lim, sh, exp_n;
    logic                 g, r, st, rnd, ovf;
    logic [FLOAT_LEN-1:0] pk, res_d;
    logic [2:0]           flg_d;

    always_comb begin
        lz    = '0;
        lim   = '0;
        sh    = '0;
        exp_n = '0;
        if (s2_q.sum[16]) begin
            norm = s2_q.sum[16:1] | {15'b0, s2_q.sum[0]};
            exp6 = {1'b0, s2_q.exp} + 6'd1;
        end else begin
            // Stop shifting at effective exponent 1; anything still
            // unnormalized there is a subnormal with exponent field 0.
            lz    = s2_q.lzc - 5'd1;
            lim   = s2_q.exp - 5'd1;
            sh    = (lz < lim) ? lz : lim;
            norm  = s2_q.sum[15:0] << sh;
            exp_n = s2_q.exp - sh;
            exp6  = norm[15] ? {1'b0, exp_n} : 6'd0;
        end
        g   = norm[4];
        r   = norm[3];
        st  = |norm[2:0];
        rnd = g && (r || st || norm[5]);
        // Rounding carry ripples into the exponent, covering 0x3FF+1 promotion.
        pk  = {exp6, norm[14:5]} + {15'b0, rnd};
        ovf = pk[15:10] >= 6'd31;

        flg_d = '0;
        if (s2_q.special) begin
            res_d              = s2_q.special_res;
            flg_d[FLG_INVALID] = s2_q.special_inv;
        end else if (ovf) begin
            res_d               = POS_INF | {s2_q.sign, 15'b0};
            flg_d[FLG_OVERFLOW] = 1'b1;
            flg_d[FLG_INEXACT]  = 1'b1;
        end else if (s2_q.sum == '0) begin
            res_d = {s2_q.zero_neg, 15'b0};
        end else begin
            res_d              = {s2_q.sign, pk[14:0]};
            flg_d[FLG_INEXACT] = g | r | st;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            s1_q      <= '0;
            s2_q      <= '0;
            result    <= '0;
            flags     <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) s1_q <= s1_d;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) s2_q <= s2_d;
            end
            if (s3_adv) begin
                out_valid <= s2_valid;
                if (s2_valid) begin
                    result <= res_d;
                    flags  <= flg_d;
                end
            end
        end
    end

endmodule

// File: doc/float16_subtractor_pipe.md
Name: float16_subtractor_pipe

Overview:
- Three-stage pipelined IEEE-754 binary16 subtractor; computes result = a - b with round-to-nearest-even.
- Companion to the float16 adder in the float16 arithmetic unit; the ALU selects between the two by opcode.
- Adds a valid/ready handshake with backpressure, full subnormal (gradual-underflow) support and exception flags, so it can sit directly on the unit's streaming operand bus.

Parameters:
- FLOAT_LEN, 16, total word width
- EXP_LEN, 5, exponent width
- MANT_LEN, 10, stored mantissa width
- GRS_LEN, 5, extra alignment bits (guard, round, 3 sticky)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands this cycle
- a  in  16  minuend, binary16
- b  in  16  subtrahend, binary16
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result this cycle
- result  out  16  a - b, binary16
- flags  out  3  {invalid, overflow, inexact}, aligned with result

Behaviour:
- Reset: all stage valid bits = 0; out_valid = 0; result = 16'h0000; flags = 3'b000; in_ready = 1 once reset deasserts. Reset mid-operation discards all in-flight data; no output appears for it.
- Transfer: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
- Stage k advances when it is empty or stage k+1 advances; stage 3 advances when !out_valid || out_ready.
- in_ready = !s1_valid || s1_advance, combinational from out_ready through the chain.
- Latency: an accepted pair appears on result exactly 3 cycles later when out_ready stays high. Throughput is 1 per cycle.
- While out_valid && !out_ready, result and flags hold stable.
- S1 (unpack/align):
  - Negate b's sign, then treat as addition.
  - Hidden bit = (exp != 0); subnormal effective exponent = 1.
  - Larger operand is chosen by {exp, mant} magnitude compare. The smaller 16-bit mantissa {hidden, mant, 5'b0} is right-shifted by the exponent difference; bits shifted out OR into the sticky LSB.
  - A shift of 16 or more yields sticky-only.
  - Special-case decode: NaN, inf, zero.
- S2 (add/count):
  - Same effective sign: 17-bit sum. Otherwise: larger minus smaller; the result is never negative.
  - Result sign = sign of the larger magnitude.
  - Leading-zero count on the 17-bit result, using the fp16_lzc sub-module.
- S3 (normalize/round/pack):
  - Carry out: shift right 1 (keep sticky), exp+1.
  - Otherwise shift left by min(lzc, exp-1). If the exponent would reach 0, leave the value subnormal with exp field 0.
  - RNE: round up if G && (R || S || LSB).
  - Mantissa carry after rounding increments the exponent. This also covers subnormal-to-normal promotion at 0x03FF+1.
  - Exponent >= 31 after rounding → ±inf (0x7C00 | sign<<15), overflow=1, inexact=1.
  - inexact = G|R|S before rounding.
- Exact zero result: +0, except (-0) - (+0) = -0 (both operands zero with result sign 1).
- Specials (override the normal path, carried through the pipe):
  - Any NaN → 16'h7E00, invalid=1 only if the NaN is signaling (mant[9]=0).
  - inf - inf with the same sign → 16'h7E00, invalid=1.
  - a inf → a.
  - b inf → b with the sign flipped.
  - Flags are otherwise 0.

Decomposition:
- Package fp16_pkg holds:
  - FLOAT_LEN, EXP_LEN, MANT_LEN, GRS_LEN
  - EXP_MAX=5'h1F, BIAS=15
  - QNAN=16'h7E00, POS_INF=16'h7C00
  - packed struct fp16_t {sign, exp, mant}
  - stage payload structs s1_t and s2_t
  - flag index constants FLG_INVALID=2, FLG_OVERFLOW=1, FLG_INEXACT=0
- Sub-module fp16_lzc: 17-bit combinational leading-zero counter, 5-bit output, count 17 for zero input. Shared later with the adder.

Test Plan:
- 3C00 - 3C00 with out_ready=1 → result 0000 (+0), flags 000, out_valid exactly 3 cycles after acceptance.
- 4200 - 3C00 (3.0-1.0) → 4000; then 3C00 - 4200 → C000; back-to-back issue gives consecutive outputs with no bubbles.
- 7C00 - 7C00 → 7E00, flags 100; 7C00 - FC00 → 7C00; 3C00 - 7C00 → FC00; 7D00 - 3C00 (sNaN) → 7E00, flags 100.
- 7BFF - FBFF → 7C00, flags 011.
- 0001 - 0002 → 8001 (subnormal, exact).
- 0400 - 0001 → 03FF (normal to subnormal).
- 3C00 - 0001 → 3C00, flags 001.
- 8000 - 0000 → 8000.
- Backpressure:
  - Issue 4 pairs with out_ready=0. in_ready drops after 3 are in flight; result/flags stay stable.
  - Then raise out_ready: all 4 results emerge in order, none lost or duplicated.
  - Assert rst_n low mid-stream: out_valid drops to 0 immediately and no stale result appears afterwards.
